// File: rtl/snake_engine.sv
// Snake movement and rendering engine: head plus shift-register body, moved one cell per update
// tick, with growth, reversal rejection, wall/self collision pulses and registered pixel hits.
module snake_engine #(
    parameter int          BIT      = 10,
    parameter int          SIZE     = 5,
    parameter int          MAX_LEN  = 16,
    parameter int          LEN_INIT = 2,
    parameter int          X_START  = 320,
    parameter int          Y_START  = 240,
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter int          WRAP     = 0,
    parameter logic [2:0]  HEAD_RGB = 3'b110,
    parameter logic [2:0]  BODY_RGB = 3'b010,
    localparam int         LW       = $clog2(MAX_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           update,
    input  logic [2:0]     direction,
    input  logic           grow,
    input  logic [1:0]     game_state,
    input  logic [BIT-1:0] x_pos,
    input  logic [BIT-1:0] y_pos,
    output logic           snake_head_active,
    output logic           snake_body_active,
    output logic [2:0]     rgb,
    output logic           self_hit,
    output logic           wall_hit,
    output logic [LW-1:0]  length
);

    localparam logic [2:0] DIR_IDLE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;
    localparam logic [1:0] GS_PLAY   = 2'b01;
    localparam logic [1:0] GS_OVER   = 2'b11;

    localparam logic [BIT-1:0] STEP  = BIT'(SIZE);
    localparam logic [BIT-1:0] XS    = BIT'(X_START);
    localparam logic [BIT-1:0] YS    = BIT'(Y_START);
    localparam logic [BIT-1:0] HMAX  = BIT'(H_RES);
    localparam logic [BIT-1:0] VMAX  = BIT'(V_RES);
    localparam logic [BIT-1:0] HLAST = BIT'(H_RES - SIZE);
    localparam logic [BIT-1:0] VLAST = BIT'(V_RES - SIZE);
    localparam logic [BIT-1:0] ZERO  = BIT'(0);
    localparam logic [BIT:0]   BOX   = (BIT+1)'(SIZE);
    localparam logic [LW-1:0]  LEN_RST  = LW'(LEN_INIT);
    localparam logic [LW-1:0]  LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0]  LEN_ONE  = LW'(1);
    localparam logic [LW-1:0]  LEN_ZERO = LW'(0);

    logic [BIT-1:0] hx_q, hx_d, hy_q, hy_d;
    logic [BIT-1:0] bx_q [MAX_LEN];
    logic [BIT-1:0] bx_d [MAX_LEN];
    logic [BIT-1:0] by_q [MAX_LEN];
    logic [BIT-1:0] by_d [MAX_LEN];
    logic [2:0]     heading_q, heading_d;
    logic           grow_pending_q, grow_pending_d;
    logic [LW-1:0]  length_q, length_d;
    logic           check_q, check_d;
    logic           self_hit_q, self_hit_d;
    logic           wall_hit_q, wall_hit_d;
    logic           head_active_q, head_active_d;
    logic           body_active_q, body_active_d;
    logic [2:0]     rgb_q, rgb_d;

    logic [BIT-1:0] nx_s, ny_s;
    logic [BIT:0]   fix_s;
    logic           blocked_s, over_s, play_s, move_s, dir_ok_s, grow_now_s;
    logic           head_hit_s, body_hit_s, self_match_s;

    // Returns {blocked, coordinate}: out-of-range values either wrap or mark the move blocked.
    function automatic logic [BIT:0] edge_fix(input logic [BIT-1:0] v, input logic [BIT-1:0] lim,
                                              input logic [BIT-1:0] wrap_to);
        if (v < lim) begin
            edge_fix = {1'b0, v};
        end else if (WRAP != 0) begin
            edge_fix = {1'b0, wrap_to};
        end else begin
            edge_fix = {1'b1, v};
        end
    endfunction

    function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
        case (a)
            DIR_UP:    is_opposite = (b == DIR_DOWN);
            DIR_DOWN:  is_opposite = (b == DIR_UP);
            DIR_LEFT:  is_opposite = (b == DIR_RIGHT);
            DIR_RIGHT: is_opposite = (b == DIR_LEFT);
            default:   is_opposite = 1'b0;
        endcase
    endfunction

    function automatic logic in_box(input logic [BIT-1:0] px, input logic [BIT-1:0] py,
                                    input logic [BIT-1:0] cx, input logic [BIT-1:0] cy);
        in_box = ({1'b0, px} >= {1'b0, cx}) && ({1'b0, px} < ({1'b0, cx} + BOX)) &&
                 ({1'b0, py} >= {1'b0, cy}) && ({1'b0, py} < ({1'b0, cy} + BOX));
    endfunction

    assign over_s     = (game_state == GS_OVER);
    assign play_s     = (game_state == GS_PLAY);
    assign move_s     = update && play_s && (heading_q != DIR_IDLE);
    assign dir_ok_s   = (direction >= DIR_UP) && (direction <= DIR_RIGHT);
    assign grow_now_s = grow_pending_q || grow;

    // Candidate head position one cell along the current heading
    always_comb begin
        nx_s      = hx_q;
        ny_s      = hy_q;
        fix_s     = {1'b0, ZERO};
        blocked_s = 1'b0;
        case (heading_q)
            DIR_UP: begin
                fix_s = edge_fix(hy_q - STEP, VMAX, VLAST);
                ny_s  = fix_s[BIT-1:0];
            end
            DIR_DOWN: begin
                fix_s = edge_fix(hy_q + STEP, VMAX, ZERO);
                ny_s  = fix_s[BIT-1:0];
            end
            DIR_LEFT: begin
                fix_s = edge_fix(hx_q - STEP, HMAX, HLAST);
                nx_s  = fix_s[BIT-1:0];
            end
            DIR_RIGHT: begin
                fix_s = edge_fix(hx_q + STEP, HMAX, ZERO);
                nx_s  = fix_s[BIT-1:0];
            end
            default: fix_s = {1'b0, ZERO};
        endcase
        blocked_s = fix_s[BIT];
    end

    // Next heading, position, body, length and wall pulse
    always_comb begin
        heading_d      = heading_q;
        hx_d           = hx_q;
        hy_d           = hy_q;
        bx_d           = bx_q;
        by_d           = by_q;
        grow_pending_d = grow_pending_q;
        length_d       = length_q;
        check_d        = 1'b0;
        wall_hit_d     = 1'b0;
        if (over_s) begin
            heading_d      = DIR_IDLE;
            hx_d           = XS;
            hy_d           = YS;
            for (int k = 0; k < MAX_LEN; k++) begin
                bx_d[k] = XS;
                by_d[k] = YS;
            end
            grow_pending_d = 1'b0;
            length_d       = LEN_RST;
        end else begin
            if (dir_ok_s && !(is_opposite(heading_q, direction) && (length_q != LEN_ZERO))) begin
                heading_d = direction;
            end else begin
                heading_d = heading_q;
            end
            if (move_s && !blocked_s) begin
                hx_d    = nx_s;
                hy_d    = ny_s;
                bx_d[0] = hx_q;
                by_d[0] = hy_q;
                for (int k = 1; k < MAX_LEN; k++) begin
                    bx_d[k] = bx_q[k-1];
                    by_d[k] = by_q[k-1];
                end
                grow_pending_d = 1'b0;
                check_d        = 1'b1;
                if (grow_now_s && (length_q < LEN_MAX)) begin
                    length_d = length_q + LEN_ONE;
                end else begin
                    length_d = length_q;
                end
            end else begin
                grow_pending_d = grow_pending_q || grow;
                wall_hit_d     = move_s && blocked_s;
            end
        end
    end

    // Pixel hits, colour and self-collision against the registered state
    always_comb begin
        head_hit_s   = in_box(x_pos, y_pos, hx_q, hy_q);
        body_hit_s   = 1'b0;
        self_match_s = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) begin
            body_hit_s   = body_hit_s   || ((k < int'(length_q)) && in_box(x_pos, y_pos, bx_q[k], by_q[k]));
            self_match_s = self_match_s || ((k < int'(length_q)) && (bx_q[k] == hx_q) && (by_q[k] == hy_q));
        end
        head_active_d = head_hit_s;
        body_active_d = body_hit_s && !head_hit_s;
        if (head_hit_s) begin
            rgb_d = HEAD_RGB;
        end else if (body_hit_s) begin
            rgb_d = BODY_RGB;
        end else begin
            rgb_d = 3'b000;
        end
        self_hit_d = check_q && self_match_s;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hx_q           <= XS;
            hy_q           <= YS;
            for (int k = 0; k < MAX_LEN; k++) begin
                bx_q[k] <= XS;
                by_q[k] <= YS;
            end
            heading_q      <= DIR_IDLE;
            grow_pending_q <= 1'b0;
            length_q       <= LEN_RST;
            check_q        <= 1'b0;
            self_hit_q     <= 1'b0;
            wall_hit_q     <= 1'b0;
            head_active_q  <= 1'b0;
            body_active_q  <= 1'b0;
            rgb_q          <= 3'b000;
        end else begin
            hx_q           <= hx_d;
            hy_q           <= hy_d;
            bx_q           <= bx_d;
            by_q           <= by_d;
            heading_q      <= heading_d;
            grow_pending_q <= grow_pending_d;
            length_q       <= length_d;
            check_q        <= check_d;
            self_hit_q     <= self_hit_d;
            wall_hit_q     <= wall_hit_d;
            head_active_q  <= head_active_d;
            body_active_q  <= body_active_d;
            rgb_q          <= rgb_d;
        end
    end

    assign snake_head_active = head_active_q;
    assign snake_body_active = body_active_q;
    assign rgb               = rgb_q;
    assign self_hit          = self_hit_q;
    assign wall_hit          = wall_hit_q;
    assign length            = length_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a walled (WRAP=0) and a wrapping (WRAP=1) instance, MAX_LEN=4,
// driven with the same stimulus and checked against hand-computed positions and pulses.
module tb_snake_engine;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] UP    = 3'd1;
    localparam logic [2:0] LEFT  = 3'd3;
    localparam logic [2:0] DOWN  = 3'd2;
    localparam logic [2:0] RIGHT = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       update = 1'b0;
    logic       grow = 1'b0;
    logic [2:0] direction = 3'd0;
    logic [1:0] game_state = 2'b01;
    logic [9:0] x_pos = 10'd0;
    logic [9:0] y_pos = 10'd0;

    logic       h0, b0, sh0, wh0, h1, b1, sh1, wh1;
    logic [2:0] rgb0, rgb1, len0, len1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    snake_engine #(.MAX_LEN(4), .WRAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .update(update), .direction(direction), .grow(grow),
        .game_state(game_state), .x_pos(x_pos), .y_pos(y_pos),
        .snake_head_active(h0), .snake_body_active(b0), .rgb(rgb0),
        .self_hit(sh0), .wall_hit(wh0), .length(len0)
    );

    snake_engine #(.MAX_LEN(4), .WRAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .update(update), .direction(direction), .grow(grow),
        .game_state(game_state), .x_pos(x_pos), .y_pos(y_pos),
        .snake_head_active(h1), .snake_body_active(b1), .rgb(rgb1),
        .self_hit(sh1), .wall_hit(wh1), .length(len1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Latch the heading for one cycle, then issue a single update
    task automatic do_move(input logic [2:0] d);
        direction = d;
        step();
        update = 1'b1;
        step();
        update = 1'b0;
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y);
        x_pos = x;
        y_pos = y;
        step();
    endtask

    int exp_len [4] = '{3, 4, 4, 4};

    initial begin
        #2 rst_n = 1'b0;
        step();
        step();
        check_val("rst_len0", len0, 2);
        check_val("rst_len1", len1, 2);
        check_val("rst_head_act", h0, 0);
        check_val("rst_rgb", rgb0, 0);
        check_val("rst_self", sh0, 0);
        check_val("rst_wall", wh0, 0);
        check_val("rst_hx", dut0.hx_q, 320);
        check_val("rst_hy", dut0.hy_q, 240);
        rst_n = 1'b1;
        step();

        // First move right
        do_move(RIGHT);
        check_val("mv_hx", dut0.hx_q, 325);
        check_val("mv_hy", dut0.hy_q, 240);
        check_val("mv_body0_x", dut0.bx_q[0], 320);
        check_val("mv_len", len0, 2);
        probe(10'd325, 10'd240);
        check_val("px_head_act", h0, 1);
        check_val("px_head_rgb", rgb0, 6);
        probe(10'd320, 10'd240);
        check_val("px_body_act", b0, 1);
        check_val("px_body_head", h0, 0);
        check_val("px_body_rgb", rgb0, 2);
        probe(10'd329, 10'd244);
        check_val("px_head_corner", h0, 1);
        probe(10'd330, 10'd240);
        check_val("px_edge_head", h0, 0);
        check_val("px_edge_rgb", rgb0, 0);

        // Reversal rejected
        do_move(LEFT);
        check_val("rev_hx", dut0.hx_q, 330);
        check_val("rev_heading", dut0.heading_q, 4);

        // Growth with saturation at MAX_LEN=4
        for (int i = 0; i < 4; i++) begin
            grow = 1'b1;
            update = 1'b1;
            step();
            grow = 1'b0;
            update = 1'b0;
            check_val("grow_len", len0, exp_len[i]);
        end
        check_val("grow_hx", dut0.hx_q, 350);

        // Square loop: head closes on body[3] after DOWN and again after RIGHT
        do_move(UP);
        step();
        check_val("sq_up_self", sh0, 0);
        do_move(LEFT);
        step();
        check_val("sq_left_self", sh0, 0);
        do_move(DOWN);
        check_val("sq_down_self_early", sh0, 0);
        step();
        check_val("sq_down_self", sh0, 1);
        step();
        check_val("sq_down_self_drop", sh0, 0);
        do_move(RIGHT);
        check_val("sq_right_self_early", sh0, 0);
        step();
        check_val("sq_right_self", sh0, 1);
        check_val("sq_right_hx", dut0.hx_q, 350);
        check_val("sq_right_hy", dut0.hy_q, 240);

        // Game over restores start state, ignoring grow
        game_state = 2'b11;
        grow = 1'b1;
        step();
        grow = 1'b0;
        game_state = 2'b01;
        check_val("go_hx", dut0.hx_q, 320);
        check_val("go_hy", dut0.hy_q, 240);
        check_val("go_len", len0, 2);
        check_val("go_heading", dut0.heading_q, 0);
        direction = IDLE;
        update = 1'b1;
        step();
        update = 1'b0;
        check_val("idle_no_move", dut0.hx_q, 320);
        do_move(RIGHT);
        check_val("go_grow_ignored", len0, 2);
        grow = 1'b1;
        step();
        grow = 1'b0;
        step();
        check_val("pend_no_move_len", len0, 2);
        do_move(RIGHT);
        check_val("pend_len", len0, 3);
        check_val("pend_hx", dut0.hx_q, 330);

        // Hold state freezes position but heading still follows direction
        game_state = 2'b00;
        update = 1'b1;
        step();
        update = 1'b0;
        check_val("hold_hx", dut0.hx_q, 330);
        direction = UP;
        step();
        check_val("hold_heading", dut0.heading_q, 1);
        direction = RIGHT;
        step();
        game_state = 2'b01;

        // Consecutive updates up to the right edge, then blocked by the wall
        update = 1'b1;
        repeat (61) step();
        update = 1'b0;
        check_val("run_hx0", dut0.hx_q, 635);
        check_val("run_hx1", dut1.hx_q, 635);
        update = 1'b1;
        step();
        update = 1'b0;
        check_val("wall_hx", dut0.hx_q, 635);
        check_val("wall_body0", dut0.bx_q[0], 630);
        check_val("wall_pulse", wh0, 1);
        check_val("wrap_r_hx", dut1.hx_q, 0);
        check_val("wrap_r_wall", wh1, 0);
        step();
        check_val("wall_pulse_end", wh0, 0);
        check_val("wall_len", len0, 3);

        // Wrap leftwards from x=0 at y=100
        direction = UP;
        step();
        update = 1'b1;
        repeat (28) step();
        update = 1'b0;
        check_val("up_hy1", dut1.hy_q, 100);
        check_val("up_hx1", dut1.hx_q, 0);
        do_move(LEFT);
        check_val("wrap_l_hx", dut1.hx_q, 635);
        check_val("wrap_l_hy", dut1.hy_q, 100);
        check_val("wrap_l_wall", wh1, 0);
        check_val("nowrap_l_hx", dut0.hx_q, 630);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised snake movement and rendering engine for the VGA snake game. It holds the head position and a shift-register body of up to MAX_LEN segments, and moves the snake one cell per `update` tick. It grows on apple collection, rejects 180° reversals, and detects self and wall collisions. It also produces registered per-pixel head/body hits and colour for the pixel mixer. It sits between the input/direction decoder, the game-state FSM (which consumes its collision pulses) and the VGA output stage.

## Interface
Parameters:
- `BIT`, 10: coordinate width.
- `SIZE`, 5: cell edge in pixels; also the step per move.
- `MAX_LEN`, 16: body segment capacity, excluding the head; range 1..64.
- `LEN_INIT`, 2: body length after reset or game over; must be ≤ MAX_LEN.
- `X_START`, 320: head start x; must be a multiple of SIZE.
- `Y_START`, 240: head start y; must be a multiple of SIZE.
- `H_RES`, 640: playfield width; must be a multiple of SIZE.
- `V_RES`, 480: playfield height; must be a multiple of SIZE.
- `WRAP`, 0: 1 = wrap at playfield edges; 0 = edge is a wall.
- `HEAD_RGB`, 3'b110: head colour.
- `BODY_RGB`, 3'b010: body colour.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `update` in 1: single-cycle move tick.
- `direction` in 3: requested direction. IDLE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4; 5–7 are treated as IDLE.
- `grow` in 1: single-cycle pulse, apple collected.
- `game_state` in 2: PLAY=2'b01, GAME_OVER=2'b11; other values mean hold.
- `x_pos`, `y_pos` in BIT: current VGA pixel.
- `snake_head_active` out 1: pixel inside head cell; registered.
- `snake_body_active` out 1: pixel inside an active body cell and not inside the head; registered.
- `rgb` out 3: HEAD_RGB, BODY_RGB, or 0 when neither is active; registered.
- `self_hit` out 1: one-cycle pulse, head overlaps an active body segment.
- `wall_hit` out 1: one-cycle pulse, move blocked by an edge. Only pulses when WRAP=0.
- `length` out clog2(MAX_LEN+1): current body length.

## Operation
- **State:**
  - head (hx, hy), BIT bits each.
  - body[0..MAX_LEN-1] (x, y).
  - `heading` (3 bits).
  - `grow_pending`.
  - `length`.
- **Reset values:**
  - head = (X_START, Y_START).
  - All body segments = (X_START, Y_START).
  - heading = IDLE, grow_pending = 0, length = LEN_INIT.
  - All outputs 0, except `length` = LEN_INIT.
- **Heading update:** every cycle, a non-IDLE `direction` is latched into `heading`. It is rejected, and heading kept, when it is the exact opposite of the current heading and length > 0.
- **Grow:** `grow` sets `grow_pending`.
- **Move:** occurs when `update` = 1, game_state = PLAY and heading ≠ IDLE.
  - The head steps SIZE in the heading direction.
  - The body shifts: body[0] ← old head, body[k] ← body[k-1].
  - If `grow_pending` (or `grow` in the same cycle) is set: length ← min(length+1, MAX_LEN), and the pending flag clears.
- **Edges:** arithmetic is modulo 2^BIT before the edge check.
  - WRAP=1: stepping left from x=0 gives H_RES−SIZE; stepping right from H_RES−SIZE gives 0; y behaves the same against V_RES.
  - WRAP=0: a move that would leave [0, H_RES)×[0, V_RES) is suppressed entirely. Head, body and length are unchanged, and `wall_hit` pulses.
- **Self-hit:** evaluated in the cycle after each completed move, on registered state. The head is compared against body[k] for k < length. Any match pulses `self_hit` for one cycle.
- **GAME_OVER:** held every cycle while active. Applies the reset values except outputs; `grow` is ignored. This takes priority over a coincident `update`.
- **Other game_state values:** hold all position state. Heading still updates.
- **Pixel logic:** the head box is x ∈ [hx, hx+SIZE), y ∈ [hy, hy+SIZE). Segments k ≥ length are never drawn and never hit.

## Timing
- Pixel outputs lag `x_pos`/`y_pos` by exactly 1 cycle.
- Position update is visible on the cycle after `update`.
- `self_hit` is asserted 2 cycles after the `update` edge.
- `wall_hit` is asserted 1 cycle after the `update` edge.
- `length` changes 1 cycle after the growing move.
- `update` asserted on consecutive cycles gives one move per cycle.
- A `grow` arriving in the same cycle as a move is applied to that move.
- Asynchronous reset takes effect mid-move. Pulses in flight are dropped.

## Test plan
- **Reset → move right:** reset; direction=RIGHT, game_state=PLAY, one `update` → head (325,240), body[0]=(320,240), length=2; pixel (325,240) gives head_active=1 one cycle later, rgb=3'b110.
- **Reversal rejected:** heading RIGHT, direction=LEFT, `update` → head x increases by 5, heading stays RIGHT.
- **Growth and saturation:** MAX_LEN=4; `grow` together with `update`, repeated 4 times → length 3, then 4, 4, 4; no wrap of the counter.
- **Wall (WRAP=0):** head (635,240) heading RIGHT, `update` → head unchanged, `wall_hit`=1 for exactly one cycle.
- **Wrap (WRAP=1):** head (0,100) heading LEFT, `update` → head (635,100), no `wall_hit`.
- **Self-hit and game over:** length 4; drive the sequence UP, LEFT, DOWN, RIGHT, one move each → `self_hit` pulses 2 cycles after the final `update`. Then game_state=GAME_OVER → head (320,240), length=2, heading IDLE.
